// File: rtl/sram_rr_arbiter_if.sv
// sram_rr_arbiter_if
//   Requester-side bus of sram_rr_arbiter: packed per-requester request
//   fields plus the shared read-response return path.
//
//   req_valid  [NREQ]         request valid per requester
//   req_ready  [NREQ]         request accepted this cycle (at most one bit set)
//   req_wmode  [NREQ]         1 = write, 0 = read
//   req_addr   [NREQ*ADDR_W]  requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata  [NREQ*DATA_W]  requester i at [i*DATA_W +: DATA_W]
//   rsp_valid  [NREQ]         one-hot read-response strobe, no back-pressure
//   rsp_rdata  [DATA_W]       read data, meaningful while any rsp_valid bit is set
//
//   Handshake: a request transfers on a rising clk edge where req_valid[i] and
//   req_ready[i] are both high. Once req_valid[i] is raised, wmode/addr/wdata
//   of requester i stay stable until that transfer. req_ready never depends on
//   anything but req_valid and the arbiter's own state. rsp_valid is a
//   one-cycle strobe that the requester must take when it appears.
interface sram_rr_arbiter_if #(
   parameter int NREQ   = 2,
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) ();
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ-1:0]        req_wmode;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*DATA_W-1:0] req_wdata;
   logic [NREQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]      rsp_rdata;

   modport master (
      output req_valid, req_wmode, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_wmode, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter
//   Round-robin arbiter/sequencer sharing one sram_wrapper (1RW macro with
//   registered wdata and rdata) among NREQ requesters. One request is accepted
//   per cycle; read data returns to the issuing requester three cycles later.
//
//   clk        single clock (also the sram_wrapper RW0_clk)
//   rst        synchronous reset, active-high
//   bus        requester bus (slave side), see sram_rr_arbiter_if
//   RW0_addr   address to sram_wrapper (registered, valid with RW0_en)
//   RW0_wdata  write data to sram_wrapper, presented one cycle ahead of RW0_en
//   RW0_en     access enable to sram_wrapper
//   RW0_wmode  1 = write, 0 = read, to sram_wrapper
//   RW0_rdata  read data from sram_wrapper
//   rd_cnt     accepted reads, saturating
//   wr_cnt     accepted writes, saturating
module sram_rr_arbiter #(
   parameter int NREQ   = 2,
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8,
   parameter int STAT_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   sram_rr_arbiter_if.slave     bus,
   output logic [ADDR_W-1:0]    RW0_addr,
   output logic [DATA_W-1:0]    RW0_wdata,
   output logic                 RW0_en,
   output logic                 RW0_wmode,
   input  logic [DATA_W-1:0]    RW0_rdata,
   output logic [STAT_W-1:0]    rd_cnt,
   output logic [STAT_W-1:0]    wr_cnt
);
   localparam int PTR_W = $clog2(NREQ);

   // One read-tracking slot: set for an accepted read, carrying its requester.
   typedef struct packed {
      logic             valid;
      logic [PTR_W-1:0] id;
   } trk_t;

   logic [PTR_W-1:0]  ptr;
   logic [PTR_W-1:0]  cand;
   logic [PTR_W-1:0]  grant_idx;
   logic              grant_any;
   logic              acc_wmode;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_wdata;
   logic              en_q;
   logic              wmode_q;
   trk_t              trk_q [3];

   // First valid requester at or after ptr, wrapping modulo NREQ.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = PTR_W'((int'(ptr) + k) % NREQ);
         if (!grant_any && bus.req_valid[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
      if (rst) grant_any = 1'b0;
   end

   always_comb begin
      bus.req_ready = '0;
      if (grant_any) bus.req_ready[grant_idx] = 1'b1;
   end

   assign acc_wmode = bus.req_wmode[grant_idx];
   assign acc_addr  = bus.req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
   assign acc_wdata = bus.req_wdata[int'(grant_idx)*DATA_W +: DATA_W];

   // The wrapper registers wdata internally, so write data leaves in the accept
   // cycle while en/addr leave one cycle later; the macro then sees all three
   // together.
   assign RW0_wdata = (grant_any && acc_wmode) ? acc_wdata : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr      <= '0;
         en_q     <= 1'b0;
         wmode_q  <= 1'b0;
         RW0_addr <= '0;
         rd_cnt   <= '0;
         wr_cnt   <= '0;
         for (int k = 0; k < 3; k++) trk_q[k] <= '0;
      end else begin
         en_q     <= grant_any;
         wmode_q  <= grant_any && acc_wmode;
         trk_q[0] <= '{valid: grant_any && !acc_wmode, id: grant_idx};
         trk_q[1] <= trk_q[0];
         trk_q[2] <= trk_q[1];
         if (grant_any) begin
            RW0_addr <= acc_addr;
            ptr      <= (int'(grant_idx) == NREQ-1) ? '0 : grant_idx + 1'b1;
            if (acc_wmode) begin
               if (wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;
            end else begin
               if (rd_cnt != '1) rd_cnt <= rd_cnt + 1'b1;
            end
         end
      end
   end

   // Gating with rst keeps a write accepted just before reset from reaching the
   // macro, since the macro samples en at the end of the reset cycle.
   assign RW0_en    = en_q & ~rst;
   assign RW0_wmode = wmode_q & ~rst;

   // Stage 2 lines up with the wrapper's registered read data.
   always_comb begin
      bus.rsp_valid = '0;
      if (trk_q[2].valid && !rst) bus.rsp_valid[trk_q[2].id] = 1'b1;
   end

   assign bus.rsp_rdata = RW0_rdata;
endmodule

// File: tb/tb_sram_rr_arbiter.sv
module tb_sram_rr_arbiter;
   localparam int NREQ = 2;
   localparam int AW   = 12;
   localparam int DW   = 8;
   localparam int EW   = NREQ + DW;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   sram_rr_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();
   logic [AW-1:0] RW0_addr;
   logic [DW-1:0] RW0_wdata, RW0_rdata;
   logic          RW0_en, RW0_wmode;
   logic [31:0]   rd_cnt, wr_cnt;

   sram_rr_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .STAT_W(32)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .RW0_addr(RW0_addr), .RW0_wdata(RW0_wdata), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
      .RW0_rdata(RW0_rdata), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
   );

   sram_rr_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) sat_bus ();
   logic [AW-1:0] sat_addr;
   logic [DW-1:0] sat_wdata;
   logic [DW-1:0] sat_rdata = '0;
   logic          sat_en, sat_wmode;
   logic [3:0]    sat_rd, sat_wr;

   sram_rr_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .STAT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .bus(sat_bus),
      .RW0_addr(sat_addr), .RW0_wdata(sat_wdata), .RW0_en(sat_en), .RW0_wmode(sat_wmode),
      .RW0_rdata(sat_rdata), .rd_cnt(sat_rd), .wr_cnt(sat_wr)
   );

   // ---------------- sram_wrapper model ----------------
   logic [DW-1:0] mem [0:4095];
   logic [DW-1:0] wdata_q, rd_raw, rdata_q;
   always @(posedge clk) begin
      wdata_q <= RW0_wdata;
      if (RW0_en) begin
         if (RW0_wmode) mem[RW0_addr] <= wdata_q;
         else           rd_raw <= mem[RW0_addr];
      end
      rdata_q <= rd_raw;
   end
   assign RW0_rdata = rdata_q;

   // ---------------- bookkeeping ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [EW-1:0]   exp_q[$];
   int              grant_log[$];
   logic [DW-1:0]   ref_mem [0:4095];
   logic [NREQ-1:0] pend_v, pend_w;
   logic [AW-1:0]   pend_a [NREQ];
   logic [DW-1:0]   pend_d [NREQ];
   logic [NREQ-1:0] last_ready;
   logic [DW-1:0]   last_wdata;
   logic [DW-1:0]   last_rsp;
   logic [EW-1:0]   mon_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (bus.rsp_valid != '0) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL rsp_unexpected: got rsp_valid=%b data=0x%0h, expected no response (t=%0t)",
                     bus.rsp_valid, bus.rsp_rdata, $time);
         end else begin
            mon_e = exp_q.pop_front();
            last_rsp = bus.rsp_rdata;
            if ({bus.rsp_valid, bus.rsp_rdata} !== mon_e) begin
               n_err++;
               $display("FAIL rsp_data: got id=%b data=0x%0h, expected id=%b data=0x%0h (t=%0t)",
                        bus.rsp_valid, bus.rsp_rdata, mon_e[EW-1:DW], mon_e[DW-1:0], $time);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic apply();
      bus.req_valid = pend_v;
      bus.req_wmode = pend_w;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_addr[i*AW +: AW]  = pend_a[i];
         bus.req_wdata[i*DW +: DW] = pend_d[i];
      end
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      pend_v[i] = 1'b1;
      pend_w[i] = w;
      pend_a[i] = a;
      pend_d[i] = d;
      apply();
   endtask

   // Observe one cycle mid-period; record accepts into the reference model.
   task automatic run_cycle();
      logic [NREQ-1:0] onehot;
      @(negedge clk);
      last_ready = bus.req_ready;
      last_wdata = RW0_wdata;
      for (int i = 0; i < NREQ; i++) begin
         if (bus.req_ready[i]) begin
            grant_log.push_back(i);
            if (pend_w[i]) ref_mem[pend_a[i]] = pend_d[i];
            else begin
               onehot    = '0;
               onehot[i] = 1'b1;
               exp_q.push_back({onehot, ref_mem[pend_a[i]]});
            end
            pend_v[i] = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      apply();
   endtask

   task automatic drain();
      int budget = 0;
      while (pend_v != '0 && budget < 20) begin
         run_cycle();
         budget++;
      end
      check("drain_requests", 32'(pend_v), 32'h0);
   endtask

   task automatic wait_rsp();
      int budget = 0;
      while (exp_q.size() != 0 && budget < 20) begin
         sync();
         budget++;
      end
      check("rsp_pending", exp_q.size(), 0);
   endtask

   // ---------------- directed tests ----------------
   logic [AW-1:0] t0_a [4] = '{12'h010, 12'h005, 12'h030, 12'h020};
   logic [DW-1:0] t0_d [4] = '{8'h11,   8'h00,   8'h33,   8'h00};
   logic          t0_w [4] = '{1'b1,    1'b0,    1'b1,    1'b0};
   logic [AW-1:0] t1_a [4] = '{12'h010, 12'h020, 12'h030, 12'h005};
   logic [DW-1:0] t1_d [4] = '{8'h00,   8'h22,   8'h00,   8'h00};
   logic          t1_w [4] = '{1'b0,    1'b1,    1'b0,    1'b0};

   initial begin
      int n0, n1, acc_n;
      bit pre_done;
      rst = 1'b1;
      pend_v = '0;
      pend_w = '0;
      for (int i = 0; i < NREQ; i++) begin
         pend_a[i] = '0;
         pend_d[i] = '0;
      end
      apply();
      sat_bus.req_valid = '0;
      sat_bus.req_wmode = '0;
      sat_bus.req_addr  = '0;
      sat_bus.req_wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Test 1: reset state with no requests
      @(negedge clk);
      check("rst_en", 32'(RW0_en), 0);
      check("rst_wmode", 32'(RW0_wmode), 0);
      check("rst_addr", 32'(RW0_addr), 0);
      check("rst_wdata", 32'(RW0_wdata), 0);
      check("rst_ready", 32'(bus.req_ready), 0);
      check("rst_rsp", 32'(bus.rsp_valid), 0);
      check("rst_rd_cnt", rd_cnt, 0);
      check("rst_wr_cnt", wr_cnt, 0);

      // Test 2: write timing then read-back to requester 1
      sync();
      issue(0, 1'b1, 12'h005, 8'hA5);
      run_cycle();
      check("wr_ready", 32'(last_ready), 32'h1);
      check("wr_wdata_early", 32'(last_wdata), 32'hA5);
      check("wr_en_a1", 32'(RW0_en), 1);
      check("wr_wmode_a1", 32'(RW0_wmode), 1);
      check("wr_addr_a1", 32'(RW0_addr), 32'h005);
      issue(1, 1'b0, 12'h005, 8'h00);
      run_cycle();
      check("rd_ready", 32'(last_ready), 32'h2);
      @(negedge clk);
      check("rd_en_b1", 32'(RW0_en), 1);
      check("rd_wmode_b1", 32'(RW0_wmode), 0);
      @(posedge clk);
      @(negedge clk);
      check("idle_en", 32'(RW0_en), 0);
      check("idle_addr_hold", 32'(RW0_addr), 32'h005);
      check("rsp_not_early", 32'(bus.rsp_valid), 0);
      @(posedge clk);
      @(negedge clk);
      check("rsp_id_b3", 32'(bus.rsp_valid), 32'h2);
      check("rsp_data_b3", 32'(bus.rsp_rdata), 32'hA5);
      sync();

      // Test 3: both requesters valid every cycle, mixed R/W
      grant_log.delete();
      n0 = 0;
      n1 = 0;
      for (int c = 0; c < 8; c++) begin
         if (!pend_v[0] && n0 < 4) begin
            issue(0, t0_w[n0], t0_a[n0], t0_d[n0]);
            n0++;
         end
         if (!pend_v[1] && n1 < 4) begin
            issue(1, t1_w[n1], t1_a[n1], t1_d[n1]);
            n1++;
         end
         run_cycle();
      end
      check("rr_grant_count", grant_log.size(), 8);
      for (int k = 0; k < grant_log.size(); k++) check($sformatf("rr_grant_%0d", k), grant_log[k], k % 2);
      drain();
      wait_rsp();
      check("cnt_rd_mixed", rd_cnt, 6);
      check("cnt_wr_mixed", wr_cnt, 4);

      // Test 4: write 0xFFF then read it in the very next cycle
      issue(0, 1'b1, 12'hFFF, 8'h3C);
      run_cycle();
      issue(1, 1'b0, 12'hFFF, 8'h00);
      run_cycle();
      check("raw_rd_ready", 32'(last_ready), 32'h2);
      wait_rsp();
      check("raw_data", 32'(last_rsp), 32'h3C);

      // Test 5: reset with two reads in flight
      issue(0, 1'b0, 12'h005, 8'h00);
      run_cycle();
      issue(1, 1'b0, 12'h010, 8'h00);
      run_cycle();
      rst = 1'b1;
      bus.req_valid = '1;
      @(negedge clk);
      check("rst_mid_ready", 32'(bus.req_ready), 0);
      check("rst_mid_en", 32'(RW0_en), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      apply();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check($sformatf("rst_drop_%0d", c), 32'(bus.rsp_valid), 0);
      end
      check("rst_mid_rd_cnt", rd_cnt, 0);
      check("rst_mid_wr_cnt", wr_cnt, 0);
      sync();
      issue(0, 1'b0, 12'h005, 8'h00);
      issue(1, 1'b0, 12'h010, 8'h00);
      run_cycle();
      check("rst_ptr_zero", 32'(last_ready), 32'h1);
      drain();
      wait_rsp();
      check("rst_rd_cnt_after", rd_cnt, 2);

      // Test 6: STAT_W=4 write counter saturates at 15
      sat_bus.req_valid = 2'b01;
      sat_bus.req_wmode = 2'b01;
      sat_bus.req_addr  = {12'h000, 12'h042};
      sat_bus.req_wdata = {8'h00, 8'h5A};
      acc_n = 0;
      pre_done = 1'b0;
      for (int c = 0; c < 40 && acc_n < 17; c++) begin
         @(negedge clk);
         if (acc_n == 14 && !pre_done) begin
            check("sat_count_14", 32'(sat_wr), 14);
            pre_done = 1'b1;
         end
         if (sat_bus.req_ready[0]) acc_n++;
      end
      check("sat_accepts", acc_n, 17);
      sync();
      sat_bus.req_valid = '0;
      @(negedge clk);
      check("sat_wr_15", 32'(sat_wr), 15);
      check("sat_rd_0", 32'(sat_rd), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("sat_wr_hold", 32'(sat_wr), 15);

      wait_rsp();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end
endmodule
